// File: rtl/stream_dot_matmul_pkg.sv
// Shared types and helpers for the streaming dot-product matrix engine.
//   state_e   : FSM state encoding (IDLE / ACC / DRAIN)
//   fw_calc   : full-precision accumulator width for a DW x DW product summed K times
//   sat_clip  : clamp a wide signed value into the signed range of an OW-bit result
package stream_dot_matmul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Working width for saturation; wide enough for any practical FW.
  localparam int SAT_W = 64;

  function automatic int fw_calc(input int dw, input int k);
    return 2 * dw + $clog2(k);
  endfunction

  function automatic logic signed [SAT_W-1:0] sat_clip(input logic signed [SAT_W-1:0] sum,
                                                       input int ow);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    if (sum > hi)      return hi;
    else if (sum < lo) return lo;
    else               return sum;
  endfunction

endpackage

// File: rtl/stream_dot_matmul_if.sv
// Operand / result stream bundle for stream_dot_matmul.
// Handshake: a transfer happens on a rising clock edge where valid && ready are
// both high; the sender holds its payload stable until that edge.
//   start            : one-cycle pulse, begin (or restart) a matrix
//   in_valid/in_ready: operand pair stream, payload a, b (signed DW)
//   out_valid/ready  : result stream, payload out_data (signed OW), qualified by
//                      out_last (final element of a matrix) and out_ovf (saturated)
// master = operand sequencer + result sink side, slave = the engine.
interface stream_dot_matmul_if #(
  parameter int DW = 8,
  parameter int OW = 17
);
  logic                 start;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] a;
  logic signed [DW-1:0] b;
  logic signed [OW-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;
  logic                 out_ovf;

  modport master (
    output start, in_valid, a, b, out_ready,
    input  in_ready, out_data, out_valid, out_last, out_ovf
  );

  modport slave (
    input  start, in_valid, a, b, out_ready,
    output in_ready, out_data, out_valid, out_last, out_ovf
  );
endinterface

// File: rtl/stream_dot_matmul_mac_sat.sv
// Datapath of the engine: signed DWxDW multiply, FW-bit accumulate, OW saturation.
//   i_a, i_b    : signed operands
//   i_acc       : running partial sum
//   o_next_acc  : i_acc + i_a*i_b at full precision
//   o_result    : o_next_acc clamped to OW bits
//   o_ovf       : o_result differs from o_next_acc (clamping happened)
module mac_sat
  import stream_dot_matmul_pkg::*;
#(
  parameter int DW = 8,
  parameter int K  = 2,
  parameter int OW = 2 * DW + $clog2(K),
  localparam int FW = fw_calc(DW, K)
) (
  input  logic signed [DW-1:0] i_a,
  input  logic signed [DW-1:0] i_b,
  input  logic signed [FW-1:0] i_acc,
  output logic signed [FW-1:0] o_next_acc,
  output logic signed [OW-1:0] o_result,
  output logic                 o_ovf
);
  logic signed [2*DW-1:0]  w_prod;
  logic signed [FW-1:0]    w_sum;
  logic signed [SAT_W-1:0] w_wide;
  logic signed [SAT_W-1:0] w_clip;

  assign w_prod     = (2*DW)'(i_a) * (2*DW)'(i_b);
  assign w_sum      = i_acc + FW'(w_prod);
  assign o_next_acc = w_sum;

  assign w_wide   = SAT_W'(w_sum);
  assign w_clip   = sat_clip(w_wide, OW);
  assign o_result = w_clip[OW-1:0];
  // With OW == FW the clamp can never bite, so this stays 0.
  assign o_ovf    = (w_clip != w_wide);
endmodule

// File: rtl/stream_dot_matmul.sv
// Streaming matrix-product engine. Each result element is the signed dot product
// of K accepted operand pairs; N_OUT elements make one matrix, the last flagged.
//   i_clk, i_rst : clock, synchronous active-high reset
//   if_bus       : operand/result streams and start pulse (slave side)
//   o_busy       : engine is not idle
//   o_state      : current FSM state, for observation
// A stalled output only blocks the pair that would complete the next element;
// START restarts from any state and drops a pending result.
module stream_dot_matmul
  import stream_dot_matmul_pkg::*;
#(
  parameter int DW    = 8,
  parameter int K     = 2,
  parameter int N_OUT = 4,
  parameter int OW    = 2 * DW + $clog2(K)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  stream_dot_matmul_if.slave    if_bus,
  output logic                  o_busy,
  output state_e                o_state
);
  localparam int FW  = fw_calc(DW, K);
  localparam int KCW = $clog2(K);
  localparam int ECW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  state_e                r_state;
  state_e                w_state_next;
  logic signed [FW-1:0]  r_acc;
  logic [KCW-1:0]        r_k_cnt;
  logic [ECW-1:0]        r_e_cnt;
  logic signed [OW-1:0]  r_out;
  logic                  r_out_valid;
  logic                  r_out_last;
  logic                  r_out_ovf;

  logic                  w_in_ready;
  logic                  w_in_fire;
  logic                  w_out_fire;
  logic                  w_k_last;
  logic                  w_e_last;
  logic                  w_complete;
  logic signed [FW-1:0]  w_next_acc;
  logic signed [OW-1:0]  w_result;
  logic                  w_ovf;

  mac_sat #(.DW(DW), .K(K), .OW(OW)) u_mac (
    .i_a        (if_bus.a),
    .i_b        (if_bus.b),
    .i_acc      (r_acc),
    .o_next_acc (w_next_acc),
    .o_result   (w_result),
    .o_ovf      (w_ovf)
  );

  assign w_k_last   = (r_k_cnt == KCW'(K - 1));
  assign w_e_last   = (r_e_cnt == ECW'(N_OUT - 1));
  assign w_in_fire  = if_bus.in_valid && w_in_ready;
  assign w_out_fire = r_out_valid && if_bus.out_ready;
  assign w_complete = w_in_fire && w_k_last;

  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (if_bus.start) w_state_next = ST_ACC;
      end
      ST_ACC: begin
        // The completing pair must wait while the previous element is stuck.
        w_in_ready = !if_bus.start &&
                     !(r_out_valid && !if_bus.out_ready && w_k_last);
        if (!if_bus.start && w_complete && w_e_last) w_state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (if_bus.start)    w_state_next = ST_ACC;
        else if (w_out_fire) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc       <= '0;
      r_k_cnt     <= '0;
      r_e_cnt     <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_ovf   <= 1'b0;
    end else if (if_bus.start) begin
      r_acc       <= '0;
      r_k_cnt     <= '0;
      r_e_cnt     <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_ovf   <= 1'b0;
    end else begin
      if (w_out_fire) r_out_valid <= 1'b0;
      // Placed after the clear so a newly completed element takes precedence.
      if (w_in_fire) begin
        if (w_k_last) begin
          r_out       <= w_result;
          r_out_valid <= 1'b1;
          r_out_last  <= w_e_last;
          r_out_ovf   <= w_ovf;
          r_acc       <= '0;
          r_k_cnt     <= '0;
          r_e_cnt     <= w_e_last ? '0 : r_e_cnt + ECW'(1);
        end else begin
          r_acc       <= w_next_acc;
          r_k_cnt     <= r_k_cnt + KCW'(1);
        end
      end
    end
  end

  assign if_bus.in_ready  = w_in_ready;
  assign if_bus.out_data  = r_out;
  assign if_bus.out_valid = r_out_valid;
  assign if_bus.out_last  = r_out_last;
  assign if_bus.out_ovf   = r_out_ovf;
  assign o_busy           = (r_state != ST_IDLE);
  assign o_state          = r_state;
endmodule

// File: tb/tb_stream_dot_matmul.sv
module tb_stream_dot_matmul;
  import stream_dot_matmul_pkg::*;

  localparam int DW    = 8;
  localparam int K     = 2;
  localparam int N_OUT = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                 start     = 1'b0;
  logic                 in_valid  = 1'b0;
  logic signed [DW-1:0] a         = '0;
  logic signed [DW-1:0] b         = '0;
  logic                 out_ready = 1'b1;

  logic   busy_full, busy_sat;
  state_e state_full, state_sat;

  stream_dot_matmul_if #(.DW(DW), .OW(17)) if_full();
  stream_dot_matmul_if #(.DW(DW), .OW(16)) if_sat();

  assign if_full.start = start;     assign if_sat.start = start;
  assign if_full.in_valid = in_valid; assign if_sat.in_valid = in_valid;
  assign if_full.a = a;             assign if_sat.a = a;
  assign if_full.b = b;             assign if_sat.b = b;
  assign if_full.out_ready = out_ready; assign if_sat.out_ready = out_ready;

  stream_dot_matmul #(.DW(DW), .K(K), .N_OUT(N_OUT), .OW(17)) u_dut (
    .i_clk(clk), .i_rst(rst), .if_bus(if_full), .o_busy(busy_full), .o_state(state_full)
  );
  stream_dot_matmul #(.DW(DW), .K(K), .N_OUT(N_OUT), .OW(16)) u_sat (
    .i_clk(clk), .i_rst(rst), .if_bus(if_sat), .o_busy(busy_sat), .o_state(state_sat)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / reference model ----------------
  typedef struct packed {
    logic signed [16:0] full;
    logic signed [15:0] sat;
    logic               ovf;
    logic               last;
  } exp_t;

  exp_t exp_q[$];
  bit   m_known = 1'b0;
  bit   m_busy  = 1'b0;
  bit   m_drain = 1'b0;
  int   m_acc   = 0;
  int   m_cnt   = 0;
  int   m_ecnt  = 0;

  always @(negedge clk) begin
    bit   exp_rdy;
    exp_t e;
    int   s;
    exp_rdy = m_busy && !m_drain && !start &&
              !((exp_q.size() != 0) && !out_ready && (m_cnt == K - 1));
    if (m_known) begin
      chk("busy", busy_full, m_busy);
      chk("busy_sat", busy_sat, m_busy);
      chk("out_valid", if_full.out_valid, exp_q.size() != 0);
      chk("out_valid_sat", if_sat.out_valid, exp_q.size() != 0);
      chk("in_ready", if_full.in_ready, exp_rdy);
      chk("in_ready_sat", if_sat.in_ready, exp_rdy);
      if (exp_q.size() != 0) begin
        chk("out_data", if_full.out_data, $signed(exp_q[0].full));
        chk("out_data_sat", if_sat.out_data, $signed(exp_q[0].sat));
        chk("out_ovf", if_full.out_ovf, 0);
        chk("out_ovf_sat", if_sat.out_ovf, exp_q[0].ovf);
        chk("out_last", if_full.out_last, exp_q[0].last);
        chk("out_last_sat", if_sat.out_last, exp_q[0].last);
      end
    end
    // Model the effect of the coming rising edge.
    if (rst) begin
      m_known = 1'b1;
      exp_q.delete();
      m_busy = 0; m_drain = 0; m_acc = 0; m_cnt = 0; m_ecnt = 0;
    end else if (start) begin
      exp_q.delete();
      m_busy = 1; m_drain = 0; m_acc = 0; m_cnt = 0; m_ecnt = 0;
    end else begin
      if (exp_q.size() != 0 && out_ready) begin
        e = exp_q.pop_front();
        if (e.last) begin m_busy = 0; m_drain = 0; end
      end
      if (in_valid && exp_rdy) begin
        m_acc += int'(a) * int'(b);
        m_cnt++;
        if (m_cnt == K) begin
          s = m_acc;
          m_ecnt++;
          e.full = 17'(s);
          e.sat  = (s > 32767) ? 16'sh7fff : (s < -32768) ? 16'sh8000 : 16'(s);
          e.ovf  = (s > 32767) || (s < -32768);
          e.last = (m_ecnt == N_OUT);
          exp_q.push_back(e);
          if (e.last) m_drain = 1;
          m_acc = 0; m_cnt = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic start_pulse();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic send_pair(input int va, input int vb);
    bit ok;
    ok = 1'b0;
    a = DW'(va); b = DW'(vb); in_valid = 1'b1;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (if_full.in_ready) ok = 1'b1;
    end
    if (!ok) chk("send_timeout", 0, 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    bit ok;
    ok = 1'b0; lat = -1;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      if (if_full.out_valid) begin ok = 1'b1; lat = t; end
    end
    if (!ok) chk("valid_timeout", 0, 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int a0, b0, a1, b1;
    int full, sat, ovf;
  } vec_t;
  vec_t tbl[6];

  initial begin
    int lat;
    tbl[0] = '{3, 4, 5, 6, 42, 42, 0};
    tbl[1] = '{-2, 7, 1, 1, -13, -13, 0};
    tbl[2] = '{-128, -128, -128, -128, 32768, 32767, 1};
    tbl[3] = '{-128, 127, -128, 127, -32512, -32512, 0};
    tbl[4] = '{127, 127, 127, 127, 32258, 32258, 0};
    tbl[5] = '{-128, -128, 127, -128, 128, 128, 0};

    // reset values
    rst = 1'b1; step(); step(); rst = 1'b0;
    @(negedge clk);
    chk("rst_out", if_full.out_data, 0);
    chk("rst_valid", if_full.out_valid, 0);
    chk("rst_last", if_full.out_last, 0);
    chk("rst_ovf", if_full.out_ovf, 0);
    chk("rst_ready", if_full.in_ready, 0);
    chk("rst_busy", busy_full, 0);
    step();

    // table: one element per fresh matrix
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      start_pulse();
      send_pair(tbl[i].a0, tbl[i].b0);
      send_pair(tbl[i].a1, tbl[i].b1);
      wait_valid(lat);
      chk("tbl_latency", lat, 0);
      chk("tbl_full", if_full.out_data, tbl[i].full);
      chk("tbl_sat", if_sat.out_data, tbl[i].sat);
      chk("tbl_ovf_sat", if_sat.out_ovf, tbl[i].ovf);
      chk("tbl_ovf_full", if_full.out_ovf, 0);
      step();
    end

    // full matrix: 4 elements, last only on the 4th, then idle
    start_pulse();
    begin
      int pa[8] = '{3, 5, -2, 1, 2, 4, -1, 6};
      int pb[8] = '{4, 6, 7, 1, 3, 5, -1, 6};
      int ev[4] = '{42, -13, 26, 37};
      for (int e = 0; e < 4; e++) begin
        send_pair(pa[2*e], pb[2*e]);
        send_pair(pa[2*e+1], pb[2*e+1]);
        wait_valid(lat);
        chk("mat_data", if_full.out_data, ev[e]);
        chk("mat_last", if_full.out_last, (e == 3) ? 1 : 0);
        step();
      end
    end
    @(negedge clk);
    chk("mat_idle_busy", busy_full, 0);
    in_valid = 1'b1; a = 8'sd9; b = 8'sd9;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      chk("idle_ignore_ready", if_full.in_ready, 0);
      chk("idle_ignore_valid", if_full.out_valid, 0);
    end
    step(); in_valid = 1'b0;

    // backpressure: stalled output blocks only the completing pair
    start_pulse();
    send_pair(1, 2); send_pair(3, 4);
    out_ready = 1'b0;
    a = 8'sd5; b = 8'sd5; in_valid = 1'b1;
    @(negedge clk);
    chk("bp_first_ready", if_full.in_ready, 1);
    step();
    a = 8'sd1; b = 8'sd1;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      chk("bp_block_ready", if_full.in_ready, 0);
      chk("bp_hold_data", if_full.out_data, 14);
      chk("bp_hold_valid", if_full.out_valid, 1);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", if_full.in_ready, 1);
    step(); in_valid = 1'b0;
    @(negedge clk);
    chk("bp_second_data", if_full.out_data, 26);
    chk("bp_second_valid", if_full.out_valid, 1);
    step();

    // restart mid-matrix with a pending element
    start_pulse();
    out_ready = 1'b0;
    send_pair(1, 1); send_pair(1, 1); send_pair(4, 4);
    start = 1'b1; in_valid = 1'b1; a = 8'sd7; b = 8'sd7;
    @(negedge clk);
    chk("restart_ready", if_full.in_ready, 0);
    step(); start = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("restart_valid", if_full.out_valid, 0);
    out_ready = 1'b1;
    step();
    send_pair(2, 2); send_pair(3, 3);
    wait_valid(lat);
    chk("restart_data", if_full.out_data, 13);
    step();

    // reset mid-element with a result pending
    start_pulse();
    out_ready = 1'b0;
    send_pair(2, 2); send_pair(2, 2); send_pair(1, 1);
    rst = 1'b1; step(); rst = 1'b0;
    @(negedge clk);
    chk("mrst_out", if_full.out_data, 0);
    chk("mrst_valid", if_full.out_valid, 0);
    chk("mrst_last", if_full.out_last, 0);
    chk("mrst_ovf", if_full.out_ovf, 0);
    chk("mrst_ready", if_full.in_ready, 0);
    chk("mrst_busy", busy_full, 0);
    chk("mrst_sat_out", if_sat.out_data, 0);
    out_ready = 1'b1;
    step();

    // randomized traffic against the scoreboard
    for (int c = 0; c < 2500; c++) begin
      rst       = ($urandom_range(0, 299) == 0);
      start     = !rst && (($urandom_range(0, 39) == 0) ||
                           (!busy_full && $urandom_range(0, 3) == 0));
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = DW'($urandom_range(0, 255));
      b         = DW'($urandom_range(0, 255));
      out_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, %0d mismatched so far", n_fail);
    $fatal(1, "timeout");
  end
endmodule
